// File: rtl/bi_link_dir_ctrl.sv
// Direction controller for one end of a bidirectional 32-bit link.
// Passes a single ownership token to the far end, with a no-drive turnaround before every hand-off.
module bi_link_dir_ctrl #(
  parameter bit INIT_OWNER = 1'b1,
  parameter int MAX_BURST  = 8,
  parameter int TURN_CYC   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  input  logic [31:0] tx_data,
  output logic        tx_ready,
  output logic        inout_select,
  output logic [31:0] link_out,
  output logic        link_valid_out,
  input  logic [31:0] link_in,
  input  logic        link_valid_in,
  output logic        rx_valid,
  output logic [31:0] rx_data,
  output logic        my_req,
  input  logic        peer_req,
  output logic        give_out,
  input  logic        give_in,
  output logic        err
);

  // state | meaning
  // OWN   | this end holds the token and may drive the bus
  // TURN  | token being released, neither end drives
  // PEER  | far end holds the token, idle here
  // REQ   | far end holds the token, my_req asserted
  typedef enum logic [1:0] {S_OWN, S_TURN, S_PEER, S_REQ} state_t;

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
  localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam state_t S_INIT = INIT_OWNER ? S_OWN : S_PEER;

  state_t          r_state;
  logic [BW-1:0]   r_burst_cnt;
  logic [TW-1:0]   r_turn_cnt;
  logic            r_give_out;
  logic            r_rx_valid;
  logic [31:0]     r_rx_data;
  logic            r_err;

  logic w_own;
  logic w_at_max;
  logic w_accept;
  logic w_release;

  assign w_own     = (r_state == S_OWN);
  assign w_at_max  = (r_burst_cnt == BW'(MAX_BURST));
  // The release decision is made before acceptance, so a full burst blocks the next flit.
  assign w_release = peer_req & (~tx_valid | w_at_max);
  assign tx_ready  = w_own & ~(peer_req & w_at_max);
  assign w_accept  = tx_valid & tx_ready;

  assign inout_select   = w_accept & ~rst;
  assign link_valid_out = w_accept & ~rst;
  assign link_out       = tx_data;
  assign my_req         = (r_state == S_REQ);
  assign give_out       = r_give_out;
  assign rx_valid       = r_rx_valid;
  assign rx_data        = r_rx_data;
  assign err            = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_INIT;
      r_burst_cnt <= '0;
      r_turn_cnt  <= '0;
      r_give_out  <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_give_out <= 1'b0;
      r_rx_valid <= link_valid_in & ~w_own;
      if (link_valid_in)
        r_rx_data <= link_in;
      if ((give_in & (w_own | (r_state == S_TURN))) | (link_valid_in & w_own))
        r_err <= 1'b1;

      case (r_state)
        S_OWN: begin
          if (w_release) begin
            r_state     <= S_TURN;
            r_burst_cnt <= '0;
            r_turn_cnt  <= TW'(TURN_CYC - 1);
          end else if (w_accept & peer_req & ~w_at_max) begin
            r_burst_cnt <= r_burst_cnt + BW'(1);
          end
        end
        S_TURN: begin
          if (r_turn_cnt == '0) begin
            r_give_out <= 1'b1;
            r_state    <= S_PEER;
          end else begin
            r_turn_cnt <= r_turn_cnt - TW'(1);
          end
        end
        S_PEER: begin
          if (give_in)
            r_state <= S_OWN;
          else if (tx_valid)
            r_state <= S_REQ;
        end
        S_REQ: begin
          if (give_in)
            r_state <= S_OWN;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_bi_link_dir_ctrl.sv
// Bench for bi_link_dir_ctrl: directed scenarios on one end, then two ends cross-wired
// with a queue scoreboard for flit delivery and bus-ownership checks.
module tb_bi_link_dir_ctrl;
  localparam int MB = 4;
  localparam int TC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pair = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic        a_tx_valid, b_tx_valid;
  logic [31:0] a_tx_data, b_tx_data;
  logic        sa_peer_req, sa_give_in, sa_lvi, sb_peer_req, sb_give_in, sb_lvi;
  logic [31:0] sa_link_in, sb_link_in;

  logic        a_tx_ready, a_sel, a_lvo, a_rx_valid, a_my_req, a_give_out, a_err;
  logic        b_tx_ready, b_sel, b_lvo, b_rx_valid, b_my_req, b_give_out, b_err;
  logic [31:0] a_link_out, a_rx_data, b_link_out, b_rx_data;

  logic        a_peer_req, a_give_in, a_lvi, b_peer_req, b_give_in, b_lvi;
  logic [31:0] a_link_in, b_link_in, bus;

  assign bus        = a_sel ? a_link_out : b_link_out;
  assign a_peer_req = pair ? b_my_req   : sa_peer_req;
  assign a_give_in  = pair ? b_give_out : sa_give_in;
  assign a_lvi      = pair ? b_lvo      : sa_lvi;
  assign a_link_in  = pair ? bus        : sa_link_in;
  assign b_peer_req = pair ? a_my_req   : sb_peer_req;
  assign b_give_in  = pair ? a_give_out : sb_give_in;
  assign b_lvi      = pair ? a_lvo      : sb_lvi;
  assign b_link_in  = pair ? bus        : sb_link_in;

  always #5 clk = ~clk;

  bi_link_dir_ctrl #(.INIT_OWNER(1'b1), .MAX_BURST(MB), .TURN_CYC(TC)) u_a (
    .clk(clk), .rst(rst), .tx_valid(a_tx_valid), .tx_data(a_tx_data), .tx_ready(a_tx_ready),
    .inout_select(a_sel), .link_out(a_link_out), .link_valid_out(a_lvo),
    .link_in(a_link_in), .link_valid_in(a_lvi), .rx_valid(a_rx_valid), .rx_data(a_rx_data),
    .my_req(a_my_req), .peer_req(a_peer_req), .give_out(a_give_out), .give_in(a_give_in),
    .err(a_err));

  bi_link_dir_ctrl #(.INIT_OWNER(1'b0), .MAX_BURST(MB), .TURN_CYC(TC)) u_b (
    .clk(clk), .rst(rst), .tx_valid(b_tx_valid), .tx_data(b_tx_data), .tx_ready(b_tx_ready),
    .inout_select(b_sel), .link_out(b_link_out), .link_valid_out(b_lvo),
    .link_in(b_link_in), .link_valid_in(b_lvi), .rx_valid(b_rx_valid), .rx_data(b_rx_data),
    .my_req(b_my_req), .peer_req(b_peer_req), .give_out(b_give_out), .give_in(b_give_in),
    .err(b_err));

  task automatic do_reset(input logic p);
    @(negedge clk);
    rst = 1'b1;
    pair = p;
    a_tx_valid = 0; b_tx_valid = 0; a_tx_data = 0; b_tx_data = 0;
    sa_peer_req = 0; sa_give_in = 0; sa_lvi = 0; sa_link_in = 0;
    sb_peer_req = 0; sb_give_in = 0; sb_lvi = 0; sb_link_in = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    @(negedge clk);
    rst = 1'b1;
    a_tx_valid = 1'b1;
    #1;
    n_checks++;
    if ({a_sel, a_lvo} !== 2'b00) $display("FAIL reset_no_drive: sel/lvo=%b%b expected 00", a_sel, a_lvo);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    a_tx_valid = 1'b0;
    #1;
    n_checks++;
    if ({a_tx_ready, a_my_req, a_give_out, a_err, a_rx_valid, a_rx_data} !== {5'b10000, 32'h0})
      $display("FAIL reset_a: rdy,req,give,err,rxv=%b%b%b%b%b rxd=%h expected 10000/0",
               a_tx_ready, a_my_req, a_give_out, a_err, a_rx_valid, a_rx_data);
    else n_pass++;
    n_checks++;
    if ({b_tx_ready, b_my_req, b_give_out, b_err, b_rx_valid, b_rx_data} !== {5'b00000, 32'h0})
      $display("FAIL reset_b: rdy,req,give,err,rxv=%b%b%b%b%b rxd=%h expected 00000/0",
               b_tx_ready, b_my_req, b_give_out, b_err, b_rx_valid, b_rx_data);
    else n_pass++;
  endtask

  task automatic test_send_three;
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_tx_valid = 1'b1;
      a_tx_data = 32'hA + i;
      #1;
      n_checks++;
      if ({a_sel, a_lvo, a_tx_ready, a_link_out} !== {3'b111, 32'hA + i})
        $display("FAIL send_three[%0d]: sel,lvo,rdy=%b%b%b data=%h expected 111/%h",
                 i, a_sel, a_lvo, a_tx_ready, a_link_out, 32'hA + i);
      else n_pass++;
    end
    @(negedge clk);
    a_tx_valid = 1'b0;
    #1;
    n_checks++;
    if ({a_sel, a_lvo} !== 2'b00) $display("FAIL send_three_idle: sel/lvo=%b%b expected 00", a_sel, a_lvo);
    else n_pass++;
  endtask

  task automatic test_rx;
    do_reset(1'b0);
    @(negedge clk);
    sb_lvi = 1'b1;
    sb_link_in = 32'h1234_5678;
    @(negedge clk);
    sb_lvi = 1'b0;
    sb_link_in = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if ({b_rx_valid, b_rx_data, b_err} !== {1'b1, 32'h1234_5678, 1'b0})
      $display("FAIL rx_capture: rxv=%b rxd=%h err=%b expected 1/12345678/0", b_rx_valid, b_rx_data, b_err);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if ({b_rx_valid, b_rx_data} !== {1'b0, 32'h1234_5678})
      $display("FAIL rx_hold: rxv=%b rxd=%h expected 0/12345678", b_rx_valid, b_rx_data);
    else n_pass++;
  endtask

  task automatic test_rx_random;
    logic        exp_v;
    logic [31:0] exp_d;
    logic        lv;
    logic [31:0] ld;
    int          errs;
    do_reset(1'b0);
    exp_v = 1'b0;
    exp_d = 32'h0;
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if ({b_rx_valid, b_rx_data} !== {exp_v, exp_d})
        $display("FAIL rx_random[%0d]: rxv=%b rxd=%h expected %b/%h", i, b_rx_valid, b_rx_data, exp_v, exp_d);
      else n_pass++;
      lv = 1'($urandom_range(0, 1));
      ld = $urandom;
      sb_lvi = lv;
      sb_link_in = ld;
      exp_v = lv;
      if (lv) exp_d = ld;
    end
  endtask

  task automatic test_turnaround;
    do_reset(1'b0);
    @(negedge clk);
    sa_peer_req = 1'b1;
    for (int k = 0; k < TC; k++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if ({a_sel, a_tx_ready, a_give_out} !== 3'b000)
        $display("FAIL turn_cycle[%0d]: sel,rdy,give=%b%b%b expected 000", k, a_sel, a_tx_ready, a_give_out);
      else n_pass++;
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({a_give_out, a_tx_ready, a_sel} !== 3'b100)
      $display("FAIL turn_give: give,rdy,sel=%b%b%b expected 100", a_give_out, a_tx_ready, a_sel);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if ({a_give_out, a_tx_ready, a_my_req} !== 3'b000)
      $display("FAIL turn_peer: give,rdy,req=%b%b%b expected 000", a_give_out, a_tx_ready, a_my_req);
    else n_pass++;
  endtask

  task automatic test_max_burst;
    int acc_cnt;
    int first_gap;
    do_reset(1'b0);
    acc_cnt = 0;
    first_gap = -1;
    @(negedge clk);
    sa_peer_req = 1'b1;
    a_tx_valid = 1'b1;
    a_tx_data = 32'h100;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (a_tx_valid && a_tx_ready) begin
        if (first_gap >= 0) first_gap = 99;
        acc_cnt++;
        @(negedge clk);
        a_tx_data = a_tx_data + 1;
      end else begin
        if (first_gap < 0) first_gap = c;
        @(negedge clk);
      end
    end
    n_checks++;
    if (acc_cnt !== MB || first_gap !== MB)
      $display("FAIL max_burst: accepted=%0d first_block_cycle=%0d expected %0d/%0d", acc_cnt, first_gap, MB, MB);
    else n_pass++;
    #1;
    n_checks++;
    if ({a_my_req, a_tx_ready} !== 2'b10)
      $display("FAIL max_burst_req: req,rdy=%b%b expected 10", a_my_req, a_tx_ready);
    else n_pass++;
    sa_give_in = 1'b1;
    @(negedge clk);
    sa_give_in = 1'b0;
    #1;
    n_checks++;
    if ({a_my_req, a_sel, a_link_out} !== {2'b01, 32'h100 + MB})
      $display("FAIL max_burst_resume: req,sel=%b%b data=%h expected 01/%h",
               a_my_req, a_sel, a_link_out, 32'h100 + MB);
    else n_pass++;
  endtask

  task automatic test_err_and_reset;
    do_reset(1'b0);
    @(negedge clk);
    sa_give_in = 1'b1;
    @(negedge clk);
    sa_give_in = 1'b0;
    #1;
    n_checks++;
    if ({a_err, a_tx_ready, a_my_req} !== 3'b110)
      $display("FAIL err_give_in_own: err,rdy,req=%b%b%b expected 110", a_err, a_tx_ready, a_my_req);
    else n_pass++;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (a_err !== 1'b1) $display("FAIL err_sticky: err=%b expected 1", a_err);
    else n_pass++;
    do_reset(1'b0);
    @(negedge clk);
    sa_lvi = 1'b1;
    sa_link_in = 32'h5555_0000;
    @(negedge clk);
    sa_lvi = 1'b0;
    #1;
    n_checks++;
    if ({a_err, a_rx_valid, a_tx_ready} !== 3'b101)
      $display("FAIL err_lvi_own: err,rxv,rdy=%b%b%b expected 101", a_err, a_rx_valid, a_tx_ready);
    else n_pass++;
    do_reset(1'b0);
    @(negedge clk);
    sa_peer_req = 1'b1;
    @(negedge clk);
    sa_give_in = 1'b1;
    #1;
    n_checks++;
    if (a_tx_ready !== 1'b0) $display("FAIL err_turn_state: rdy=%b expected 0", a_tx_ready);
    else n_pass++;
    @(negedge clk);
    sa_give_in = 1'b0;
    a_tx_valid = 1'b1;
    a_tx_data = 32'hCAFE_0001;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({a_give_out, a_err, a_tx_ready, a_sel} !== 4'b0010)
      $display("FAIL reset_mid_turn: give,err,rdy,sel=%b%b%b%b expected 0010",
               a_give_out, a_err, a_tx_ready, a_sel);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    sa_peer_req = 1'b0;
    #1;
    n_checks++;
    if ({a_sel, a_link_out} !== {1'b1, 32'hCAFE_0001})
      $display("FAIL reset_token_back: sel=%b data=%h expected 1/cafe0001", a_sel, a_link_out);
    else n_pass++;
  endtask

  task automatic test_pair_traffic(input bit rnd, input int ncyc);
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic        a_acc, b_acc, gen;
    int          a_cnt, b_cnt, na, nb;
    int          cur, run_own, run_len, prev_own, idle_cnt, nruns;
    do_reset(1'b1);
    a_acc = 0; b_acc = 0; a_cnt = 0; b_cnt = 0; na = 0; nb = 0;
    run_own = 0; run_len = 0; prev_own = 0; idle_cnt = 0; nruns = 0;
    for (int cyc = 0; cyc < ncyc + 60; cyc++) begin
      @(negedge clk);
      gen = (cyc < ncyc);
      if (!a_tx_valid || a_acc) begin
        a_tx_valid = gen && (!rnd || $urandom_range(0, 3) != 0);
        a_tx_data = rnd ? $urandom : 32'hA000_0000 + a_cnt;
        a_cnt++;
      end
      if (!b_tx_valid || b_acc) begin
        b_tx_valid = gen && (!rnd || $urandom_range(0, 3) != 0);
        b_tx_data = rnd ? $urandom : 32'hB000_0000 + b_cnt;
        b_cnt++;
      end
      #1;
      if (b_rx_valid) begin
        n_checks++;
        if (qa.size() == 0) $display("FAIL pair_rx_b: got %h with nothing outstanding", b_rx_data);
        else if (b_rx_data !== qa[0]) $display("FAIL pair_rx_b: got %h expected %h", b_rx_data, qa[0]);
        else n_pass++;
        if (qa.size() != 0) void'(qa.pop_front());
      end
      if (a_rx_valid) begin
        n_checks++;
        if (qb.size() == 0) $display("FAIL pair_rx_a: got %h with nothing outstanding", a_rx_data);
        else if (a_rx_data !== qb[0]) $display("FAIL pair_rx_a: got %h expected %h", a_rx_data, qb[0]);
        else n_pass++;
        if (qb.size() != 0) void'(qb.pop_front());
      end
      n_checks++;
      if (a_sel && b_sel) $display("FAIL pair_both_drive: cycle %0d both ends drive", cyc);
      else n_pass++;
      a_acc = a_tx_valid & a_tx_ready;
      b_acc = b_tx_valid & b_tx_ready;
      if (a_acc) begin qa.push_back(a_tx_data); na++; end
      if (b_acc) begin qb.push_back(b_tx_data); nb++; end
      cur = a_sel ? 1 : (b_sel ? 2 : 0);
      if (cur != 0 && cur == run_own) begin
        run_len++;
      end else begin
        if (run_own != 0) begin
          nruns++;
          if (!rnd && gen) begin
            n_checks++;
            if ((nruns == 1 && (run_len < 1 || run_len > MB + 1)) || (nruns > 1 && run_len != MB))
              $display("FAIL pair_burst_len: run %0d owner %0d length %0d expected %0d",
                       nruns, run_own, run_len, MB);
            else n_pass++;
          end
          prev_own = run_own;
          idle_cnt = 0;
        end
        if (cur != 0) begin
          if (prev_own != 0 && cur != prev_own) begin
            n_checks++;
            if (idle_cnt < TC) $display("FAIL pair_gap: %0d idle cycles expected >= %0d", idle_cnt, TC);
            else n_pass++;
          end
          if (!rnd && prev_own != 0 && gen) begin
            n_checks++;
            if (cur == prev_own) $display("FAIL pair_alternate: owner %0d twice in a row", cur);
            else n_pass++;
          end
          run_own = cur;
          run_len = 1;
        end else begin
          run_own = 0;
          idle_cnt++;
        end
      end
    end
    n_checks++;
    if (qa.size() != 0 || qb.size() != 0 || na == 0 || nb == 0 || a_tx_valid || b_tx_valid)
      $display("FAIL pair_drain: undelivered a=%0d b=%0d sent a=%0d b=%0d pending=%b%b expected 0/0/>0/>0/00",
               qa.size(), qb.size(), na, nb, a_tx_valid, b_tx_valid);
    else n_pass++;
    n_checks++;
    if ({a_err, b_err} !== 2'b00 || (!rnd && nruns < 4))
      $display("FAIL pair_status: err=%b%b runs=%0d expected 00 and >=4 runs", a_err, b_err, nruns);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_send_three;
    test_rx;
    test_rx_random;
    test_turnaround;
    test_max_burst;
    test_err_and_reset;
    test_pair_traffic(1'b0, 80);
    test_pair_traffic(1'b1, 300);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
